// File: rtl/mcc_pkg.sv
// Shared types for the multi-cycle controller: FSM states, opcodes and datapath select encodings.
// MCC_ILLEGAL_TRAP_EN selects whether illegal opcodes trap or execute as NOP.
package mcc_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_NEG  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_BRZ  = 4'b1001;
   localparam logic [3:0] OP_JM   = 4'b1010;
   localparam logic [3:0] OP_BRN  = 4'b1011;
   localparam logic [3:0] OP_LD   = 4'b1110;
   localparam logic [3:0] OP_SVPC = 4'b1111;

   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_NEG  = 3'd3,
      ALU_INC  = 3'd4
   } alu_op_t;

   typedef enum logic [1:0] {
      PC_INC = 2'd0,
      PC_RS  = 2'd1,
      PC_MEM = 2'd2
   } pc_src_t;

   typedef enum logic [1:0] {
      WB_ALU   = 2'd0,
      WB_MEM   = 2'd1,
      WB_PCIMM = 2'd2
   } wb_src_t;

   // Instruction classes: each class has one fixed path through the FSM.
   typedef enum logic [3:0] {
      CLS_NOP  = 4'd0,
      CLS_J    = 4'd1,
      CLS_BRZ  = 4'd2,
      CLS_BRN  = 4'd3,
      CLS_ALU  = 4'd4,
      CLS_LD   = 4'd5,
      CLS_ST   = 4'd6,
      CLS_JM   = 4'd7,
      CLS_SVPC = 4'd8
   } iclass_t;

`ifdef MCC_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

endpackage

// File: rtl/mcc_decode.sv
// Combinational opcode decode: instruction class, ALU operation and illegal-opcode flag.
// Illegal opcodes report class NOP so the non-trapping build runs them as NOP.
module mcc_decode
   import mcc_pkg::*;
(
   input  logic [3:0] opcode,
   output iclass_t    cls,
   output alu_op_t    alu_op,
   output logic       illegal
);

   always_comb begin
      cls     = CLS_NOP;
      alu_op  = ALU_PASS;
      illegal = 1'b0;
      case (opcode)
         OP_NOP:  cls = CLS_NOP;
         OP_ST:   cls = CLS_ST;
         OP_ADD:  begin cls = CLS_ALU; alu_op = ALU_ADD; end
         OP_INC:  begin cls = CLS_ALU; alu_op = ALU_INC; end
         OP_NEG:  begin cls = CLS_ALU; alu_op = ALU_NEG; end
         OP_SUB:  begin cls = CLS_ALU; alu_op = ALU_SUB; end
         OP_J:    cls = CLS_J;
         OP_BRZ:  cls = CLS_BRZ;
         OP_JM:   cls = CLS_JM;
         OP_BRN:  cls = CLS_BRN;
         OP_LD:   cls = CLS_LD;
         OP_SVPC: cls = CLS_SVPC;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with Z/N flags and a retire counter.
// Define MCC_ILLEGAL_TRAP_EN to make illegal opcodes enter a sticky TRAP state.
module multicycle_controller
   import mcc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [31:0]      instr,
   input  logic [31:0]      alu_result,
   output logic             ir_wrt,
   output logic             pc_wrt,
   output logic [1:0]       pc_src,
   output logic             reg_wrt,
   output logic [1:0]       wb_src,
   output logic             mem_read,
   output logic             mem_wrt,
   output logic [2:0]       alu_op,
   output logic             flag_z,
   output logic             flag_n,
   output logic             busy,
   output logic [CNT_W-1:0] retired,
   output logic             trap
);

   state_t     state, state_nx;
   logic [3:0] opcode;
   iclass_t    cls;
   alu_op_t    dec_alu;
   logic       illegal;
   logic       trap_hit;
   logic       retire;
   logic       trap_q;
   logic       unused_instr;

   assign unused_instr = ^instr[27:0];

   mcc_decode u_decode (
      .opcode  (opcode),
      .cls     (cls),
      .alu_op  (dec_alu),
      .illegal (illegal)
   );

   // Constant-folds to 0 when trapping is not compiled in.
   assign trap_hit = TRAP_EN & illegal;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Architectural state: latched opcode, flags, retire counter, trap
   always_ff @(posedge clk) begin
      if (rst) begin
         opcode  <= OP_NOP;
         flag_z  <= 1'b0;
         flag_n  <= 1'b0;
         retired <= '0;
         trap_q  <= 1'b0;
      end else begin
         if (state == S_FETCH) opcode <= instr[31:28];
         if (retire) retired <= retired + CNT_W'(1);
         if (state == S_WB && cls == CLS_ALU) begin
            flag_z <= (alu_result == 32'h0);
            flag_n <= alu_result[31];
         end
         if (state == S_DECODE && trap_hit) trap_q <= 1'b1;
      end
   end

   assign trap = trap_q;

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start && !stop) state_nx = S_FETCH;
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: begin
            if (trap_hit) state_nx = S_TRAP;
            else begin
               case (cls)
                  CLS_ALU:               state_nx = S_EXEC;
                  CLS_LD, CLS_ST, CLS_JM: state_nx = S_MEM;
                  CLS_SVPC:              state_nx = S_WB;
                  default:               state_nx = stop ? S_IDLE : S_FETCH;
               endcase
            end
         end
         S_EXEC:   state_nx = S_WB;
         S_MEM:    state_nx = (cls == CLS_ST) ? (stop ? S_IDLE : S_FETCH) : S_WB;
         // JM completes by reloading the PC from memory; it always continues to FETCH.
         S_WB:     state_nx = (cls == CLS_JM) ? S_FETCH : (stop ? S_IDLE : S_FETCH);
         S_TRAP:   state_nx = S_TRAP;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Moore output decode from state and latched opcode
   always_comb begin
      ir_wrt   = 1'b0;
      pc_wrt   = 1'b0;
      pc_src   = PC_INC;
      reg_wrt  = 1'b0;
      wb_src   = WB_ALU;
      mem_read = 1'b0;
      mem_wrt  = 1'b0;
      alu_op   = ALU_PASS;
      retire   = 1'b0;
      busy     = (state != S_IDLE) && (state != S_TRAP);
      case (state)
         S_FETCH: ir_wrt = 1'b1;
         S_DECODE: begin
            if (!trap_hit) begin
               case (cls)
                  CLS_NOP: begin pc_wrt = 1'b1; retire = 1'b1; end
                  CLS_J:   begin pc_wrt = 1'b1; pc_src = PC_RS; retire = 1'b1; end
                  CLS_BRZ: begin
                     pc_wrt = 1'b1;
                     pc_src = flag_z ? PC_RS : PC_INC;
                     retire = 1'b1;
                  end
                  CLS_BRN: begin
                     pc_wrt = 1'b1;
                     pc_src = flag_n ? PC_RS : PC_INC;
                     retire = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_EXEC: alu_op = dec_alu;
         S_MEM: begin
            if (cls == CLS_ST) begin
               mem_wrt = 1'b1;
               pc_wrt  = 1'b1;
               retire  = 1'b1;
            end else begin
               mem_read = 1'b1;
            end
         end
         S_WB: begin
            pc_wrt = 1'b1;
            retire = 1'b1;
            case (cls)
               CLS_ALU:  begin reg_wrt = 1'b1; alu_op = dec_alu; end
               CLS_LD:   begin reg_wrt = 1'b1; wb_src = WB_MEM; end
               CLS_SVPC: begin reg_wrt = 1'b1; wb_src = WB_PCIMM; end
               CLS_JM:   pc_src = PC_MEM;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control words, flags, counter wrap, stop/reset, trap.
// Follows MCC_ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_multicycle_controller;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst, start, stop;
   logic [31:0]      instr, alu_result;
   logic             ir_wrt, pc_wrt, reg_wrt, mem_read, mem_wrt;
   logic [1:0]       pc_src, wb_src;
   logic [2:0]       alu_op;
   logic             flag_z, flag_n, busy, trap;
   logic [CNT_W-1:0] retired;

   int n_tests = 0;
   int n_fail  = 0;

   multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .instr      (instr),
      .alu_result (alu_result),
      .ir_wrt     (ir_wrt),
      .pc_wrt     (pc_wrt),
      .pc_src     (pc_src),
      .reg_wrt    (reg_wrt),
      .wb_src     (wb_src),
      .mem_read   (mem_read),
      .mem_wrt    (mem_wrt),
      .alu_op     (alu_op),
      .flag_z     (flag_z),
      .flag_n     (flag_n),
      .busy       (busy),
      .retired    (retired),
      .trap       (trap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ctl();
      return {19'b0, ir_wrt, pc_wrt, pc_src, reg_wrt, wb_src, mem_read, mem_wrt, alu_op, busy};
   endfunction

   // Expected control word: ir, pc_wrt, pc_src, reg_wrt, wb_src, mem_read, mem_wrt, alu_op, busy
   function automatic logic [31:0] mk(bit ir, bit pw, logic [1:0] ps, bit rw, logic [1:0] ws,
                                      bit mr, bit mw, logic [2:0] ao, bit b);
      return {19'b0, ir, pw, ps, rw, ws, mr, mw, ao, b};
   endfunction

   function automatic logic [31:0] op(logic [3:0] code);
      return {code, 28'h0abc123};
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; instr = 32'h0; alu_result = 32'h0;
      tick(); tick();
      check("rst_ctl", ctl(), 32'h0);
      check("rst_retired", 32'(retired), 32'h0);
      check("rst_flags", {30'b0, flag_z, flag_n}, 32'h0);
      check("rst_trap", {31'b0, trap}, 32'h0);
      rst = 1'b0;

      // ADD: FETCH, DECODE, EXEC, WB
      start = 1'b1; tick(); start = 1'b0;
      check("add_fetch", ctl(), mk(1,0,0,0,0,0,0,0,1));
      instr = op(4'b0100); alu_result = 32'h8000_0000;
      tick(); check("add_decode", ctl(), mk(0,0,0,0,0,0,0,0,1));
      tick(); check("add_exec", ctl(), mk(0,0,0,0,0,0,0,3'd1,1));
      tick(); check("add_wb", ctl(), mk(0,1,0,1,0,0,0,3'd1,1));
      check("add_wb_retired", 32'(retired), 32'd0);
      tick(); check("add_retired", 32'(retired), 32'd1);
      check("add_flags", {30'b0, flag_z, flag_n}, 32'b01);
      check("fetch_after_add", ctl(), mk(1,0,0,0,0,0,0,0,1));

      // SUB -> 0, then BRZ taken
      instr = op(4'b0111); alu_result = 32'h0;
      tick(); tick(); check("sub_exec", ctl(), mk(0,0,0,0,0,0,0,3'd2,1));
      tick(); tick();
      check("sub_flags", {30'b0, flag_z, flag_n}, 32'b10);
      check("sub_retired", 32'(retired), 32'd2);
      instr = op(4'b1001);
      tick(); check("brz_taken", ctl(), mk(0,1,2'd1,0,0,0,0,0,1));
      tick(); check("brz_retired", 32'(retired), 32'd3);

      // INC -> 5, then BRZ not taken
      instr = op(4'b0101); alu_result = 32'h5;
      tick(); tick(); check("inc_exec", ctl(), mk(0,0,0,0,0,0,0,3'd4,1));
      tick(); check("inc_wb", ctl(), mk(0,1,0,1,0,0,0,3'd4,1));
      tick(); check("inc_flags", {30'b0, flag_z, flag_n}, 32'b00);
      instr = op(4'b1001);
      tick(); check("brz_not_taken", ctl(), mk(0,1,2'd0,0,0,0,0,0,1));
      tick();

      // J
      instr = op(4'b1000);
      tick(); check("j_decode", ctl(), mk(0,1,2'd1,0,0,0,0,0,1));
      tick(); check("j_retired", 32'(retired), 32'd6);

      // LD: flags must not change even with a zero ALU result
      instr = op(4'b1110); alu_result = 32'h0;
      tick();
      tick(); check("ld_mem", ctl(), mk(0,0,0,0,0,1,0,0,1));
      tick(); check("ld_wb", ctl(), mk(0,1,0,1,2'd1,0,0,0,1));
      tick(); check("ld_flags", {30'b0, flag_z, flag_n}, 32'b00);
      check("ld_retired", 32'(retired), 32'd7);

      // ST: one write cycle, 3-cycle retire
      instr = op(4'b0011);
      tick();
      tick(); check("st_mem", ctl(), mk(0,1,0,0,0,0,1,0,1));
      tick(); check("st_after", ctl(), mk(1,0,0,0,0,0,0,0,1));
      check("st_retired", 32'(retired), 32'd8);

      // SVPC
      instr = op(4'b1111);
      tick();
      tick(); check("svpc_wb", ctl(), mk(0,1,0,1,2'd2,0,0,0,1));
      tick(); check("svpc_retired", 32'(retired), 32'd9);

      // JM
      instr = op(4'b1010);
      tick();
      tick(); check("jm_mem", ctl(), mk(0,0,0,0,0,1,0,0,1));
      tick(); check("jm_wb", ctl(), mk(0,1,2'd2,0,0,0,0,0,1));
      tick(); check("jm_retired", 32'(retired), 32'd10);

      // Stop raised during EXEC of ADD: WB completes, then IDLE
      instr = op(4'b0100); alu_result = 32'h1;
      tick(); tick(); stop = 1'b1;
      tick(); check("stop_wb", ctl(), mk(0,1,0,1,0,0,0,3'd1,1));
      tick(); check("stop_idle", ctl(), 32'h0);
      check("stop_retired", 32'(retired), 32'd11);

      // start and stop together in IDLE: stay idle
      start = 1'b1;
      tick(); check("start_stop", ctl(), 32'h0);
      start = 1'b0; stop = 1'b0;
      tick(); check("still_idle", ctl(), 32'h0);

      // Reset during MEM of LD
      start = 1'b1; tick(); start = 1'b0;
      instr = op(4'b1110);
      tick();
      tick(); check("rst_ld_mem", ctl(), mk(0,0,0,0,0,1,0,0,1));
      rst = 1'b1;
      tick(); rst = 1'b0;
      check("rst_ld_ctl", ctl(), 32'h0);
      check("rst_ld_retired", 32'(retired), 32'd0);

      // Illegal opcode 1101
      start = 1'b1; tick(); start = 1'b0;
      instr = op(4'b1101);
`ifdef MCC_ILLEGAL_TRAP_EN
      tick(); check("ill_decode", ctl(), mk(0,0,0,0,0,0,0,0,1));
      tick(); check("ill_trap", {31'b0, trap}, 32'd1);
      check("ill_trap_ctl", ctl(), 32'h0);
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         start = 1'b0;
         check("trap_hold", {27'b0, trap, busy, pc_wrt, retired == 4'd0, ir_wrt}, 32'b10010);
      end
`else
      tick(); check("ill_decode", ctl(), mk(0,1,0,0,0,0,0,0,1));
      tick(); check("ill_retired", 32'(retired), 32'd1);
      check("ill_no_trap", {31'b0, trap}, 32'd0);
`endif
      rst = 1'b1; tick(); rst = 1'b0;

      // Counter wrap with CNT_W = 4
      start = 1'b1; tick(); start = 1'b0;
      instr = op(4'b0000);
      for (int i = 0; i < 15; i++) begin
         tick(); tick();
      end
      check("wrap_15", 32'(retired), 32'd15);
      tick(); check("nop_decode", ctl(), mk(0,1,0,0,0,0,0,0,1));
      tick(); check("wrap_0", 32'(retired), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control sequencer for the 32-bit, 4-bit-opcode core. It owns the instruction-memory, register-file and data-memory strobes and moves each instruction through FETCH/DECODE/EXEC/MEM/WB. It sits between the opcode field of the instruction register and the datapath muxes, and tracks the Z/N condition flags used by branches. All control outputs change on `posedge clk`, so the negedge-sampled memories and register file see them stable half a cycle later.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; leaves IDLE.
- `stop`  in  1  level; returns to IDLE at the next instruction boundary.
- `instr`  in  32  instruction-memory output; `[31:28]` is the opcode.
- `alu_result`  in  32  ALU output; sampled in WB for the flags.
- `ir_wrt`  out  1  load the instruction register.
- `pc_wrt`  out  1  load the PC.
- `pc_src`  out  2  PC source: 0 = PC+1, 1 = rs, 2 = mem data.
- `reg_wrt`  out  1  register-file write enable.
- `wb_src`  out  2  write-back source: 0 = ALU, 1 = mem, 2 = PC+imm.
- `mem_read`  out  1  data-memory read strobe.
- `mem_wrt`  out  1  data-memory write strobe.
- `alu_op`  out  3  ALU operation: 0 PASS, 1 ADD, 2 SUB, 3 NEG, 4 INC (rs + unsigned rt field).
- `flag_z`, `flag_n`  out  1  condition flags.
- `busy`  out  1  high in every state except IDLE and TRAP.
- `retired`  out  CNT_W  count of completed instructions.
- `trap`  out  1  illegal opcode seen (only when trapping is compiled in).

## Operation
- **Opcodes:** NOP 0000, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111, J 1000, BRZ 1001, JM 1010, BRN 1011, LD 1110, SVPC 1111. Codes 0001, 0010, 1100 and 1101 are illegal.
- **FETCH:** `ir_wrt`=1. The opcode is latched internally at the end of the cycle.
- **DECODE:**
  - NOP: retire.
  - J: retire with `pc_src`=1.
  - BRZ: retire with `pc_src` = `flag_z` ? 1 : 0.
  - BRN: retire with `pc_src` = `flag_n` ? 1 : 0.
  - ADD, SUB, INC, NEG: go to EXEC.
  - LD, ST, JM: go to MEM.
  - SVPC: go to WB.
- **EXEC:** `alu_op` driven from the opcode; next state is WB.
- **MEM:**
  - LD and JM: `mem_read`=1, next state WB.
  - ST: `mem_wrt`=1, then retire.
- **WB:**
  - ALU ops: `reg_wrt`=1, `wb_src`=0, `alu_op` held. Flags load `flag_z` = (`alu_result`==0) and `flag_n` = `alu_result[31]`. Then retire.
  - LD: `reg_wrt`=1, `wb_src`=1, retire.
  - SVPC: `reg_wrt`=1, `wb_src`=2, retire.
  - JM: `pc_wrt`=1, `pc_src`=2, `retired` increments, next state FETCH.
- **Retire** means, in the same cycle:
  - `pc_wrt`=1 with `pc_src`=0 unless stated otherwise above.
  - `retired` increments.
  - Next state is FETCH, or IDLE if `stop`=1.
- Only ALU ops update the flags. LD and SVPC leave them unchanged.
- Outputs are a Moore decode of the registered state and the latched opcode. Any output not listed for a state is 0.

## Timing
- **Reset** (`rst`=1 at posedge): state = IDLE; `flag_z`, `flag_n`, `retired`, `trap` and the latched opcode = 0; every output = 0. Reset takes priority over `start`, `stop` and any in-flight instruction. A partially executed instruction is abandoned with no write strobes.
- **Cycles per instruction (FETCH to retire):** NOP, J, BRZ, BRN = 2; ST, SVPC = 3; ALU ops, LD, JM = 4.
- **Start:**
  - `start` is ignored outside IDLE.
  - IDLE with `start`=1 goes to FETCH on the next edge.
  - `start` and `stop` both high in IDLE: `stop` wins, so the block stays in IDLE.
- **Stop:** sampled only in the retire cycle, so an instruction is never split.
- **Counter:** `retired` wraps modulo 2^CNT_W with no saturation.
- **Branches:** a branch issued directly after an ALU op sees the flags written in that op's WB cycle.

## Configuration
- `MCC_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE enters state TRAP and sets `trap`=1.
  - In TRAP, `busy`=0, all strobes are 0, and the PC and `retired` are unchanged.
  - Only `rst` leaves TRAP.
- `MCC_ILLEGAL_TRAP_EN` undefined: illegal opcodes execute as NOP, and `trap` is tied to 0.

## Structure
- **Shared package `mcc_pkg`:**
  - state enumeration: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP;
  - 4-bit opcode constants;
  - `alu_op`, `pc_src` and `wb_src` encodings.
- **Sub-module `mcc_decode`:** combinational opcode-class decode (class, `alu_op`, illegal flag), instantiated once.

## Test plan
- After `rst`, pulse `start`; feed ADD (0100). Expect states FETCH, DECODE, EXEC, WB. In WB, `reg_wrt`=1 and `alu_op`=1; `retired`=1 after 4 cycles.
- SUB with `alu_result`=32'h0, then BRZ → `flag_z`=1; the BRZ DECODE cycle drives `pc_wrt`=1, `pc_src`=1. Then INC with `alu_result`=32'h5, then BRZ → `pc_src`=0.
- LD (1110) → `mem_read`=1 in MEM, then `reg_wrt`=1 and `wb_src`=1 in WB. ST (0011) → `mem_wrt`=1 for exactly one cycle, then 3-cycle retire.
- Assert `stop` during EXEC of an ADD → the WB write still happens, then IDLE with `busy`=0. Assert `rst` in MEM of LD → no `reg_wrt`; all outputs 0 next cycle.
- Opcode 1101 with `MCC_ILLEGAL_TRAP_EN` defined → `trap`=1 and the block stays in TRAP for 10 cycles despite `start`. Without the macro → 2-cycle NOP and `retired` increments.
- Preload `retired` near wrap (CNT_W=4, 15 retires) → the 16th retire reads 0.
